mode_switch_controller: RTL



---
 rtl/mode_ctrl_pkg.sv | 21 ++
 rtl/mode_select_sync.sv | 26 ++
 rtl/mode_switch_controller.sv | 120 ++++++++++++
 3 files changed

// File: rtl/mode_ctrl_pkg.sv
// Shared types and helpers for the ADC front-end mode controller.
// Mode one-hot constants follow the default XADC / PWM / R2R bit order.
package mode_ctrl_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    ON   = 2'd1,
    DEAD = 2'd2
  } state_t;

  localparam logic [2:0] MODE_XADC = 3'b001;
  localparam logic [2:0] MODE_PWM  = 3'b010;
  localparam logic [2:0] MODE_R2R  = 3'b100;

  function automatic logic is_onehot_or_zero(
    input logic [31:0] v
  );
    return (v & (v - 32'd1)) == 32'd0;
  endfunction

endpackage

// File: rtl/mode_select_sync.sv
// Two-flop synchroniser for asynchronous board mode switches.
// Compiled only when SYNC_INPUT_EN is defined.
`ifdef SYNC_INPUT_EN
module mode_select_sync #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule
`endif

// File: rtl/mode_switch_controller.sv
// Break-before-make mode controller for XADC / PWM / R2R paths.
// Define SYNC_INPUT_EN to pass mode_select through a 2-flop synchroniser.
module mode_switch_controller
  import mode_ctrl_pkg::*;
#(
  parameter int                   NUM_MODES     = 3,
  parameter int                   DEAD_CYCLES   = 16,
  parameter logic [NUM_MODES-1:0] DISCRETE_MASK = 3'b110
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_MODES-1:0] mode_select,
  input  logic                 err_clr,
  output logic [NUM_MODES-1:0] mode_enable,
  output logic                 discrete_adc_enable,
  output logic [NUM_MODES-1:0] active_mode,
  output logic                 busy,
  output logic                 sel_error
);

  localparam int CW = $clog2(DEAD_CYCLES + 1);

  logic [NUM_MODES-1:0] sel;

`ifdef SYNC_INPUT_EN
  mode_select_sync #(
    .W(NUM_MODES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (mode_select),
    .q    (sel)
  );
`else
  assign sel = mode_select;
`endif

  state_t               state, state_nx;
  logic [CW-1:0]        cnt, cnt_nx;
  logic [NUM_MODES-1:0] pend, pend_nx;
  logic [NUM_MODES-1:0] en_q, en_nx;
  logic [NUM_MODES-1:0] act_q, act_nx;
  logic                 disc_q, disc_nx;
  logic                 err_q, err_nx;
  logic                 wf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= OFF;
      cnt    <= '0;
      pend   <= '0;
      en_q   <= '0;
      act_q  <= '0;
      disc_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      pend   <= pend_nx;
      en_q   <= en_nx;
      act_q  <= act_nx;
      disc_q <= disc_nx;
      err_q  <= err_nx;
    end
  end

  always_comb begin
    wf       = is_onehot_or_zero(32'(sel));
    state_nx = state;
    cnt_nx   = cnt;
    pend_nx  = pend;
    en_nx    = en_q;
    act_nx   = act_q;
    err_nx   = !wf ? 1'b1 : (err_clr ? 1'b0 : err_q);
    unique case (state)
      OFF: begin
        if (wf && sel != act_q) begin
          state_nx = ON;
          en_nx    = sel;
          act_nx   = sel;
        end
      end
      ON: begin
        if (wf && sel != act_q) begin
          state_nx = DEAD;
          en_nx    = '0;
          cnt_nx   = CW'(DEAD_CYCLES);
          pend_nx  = sel;
        end
      end
      DEAD: begin
        // Retargeting never restarts the dead time.
        if (wf) pend_nx = sel;
        cnt_nx = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          cnt_nx = '0;
          if (pend_nx == '0) begin
            state_nx = OFF;
            act_nx   = '0;
          end else begin
            state_nx = ON;
            en_nx    = pend_nx;
            act_nx   = pend_nx;
          end
        end
      end
      default: state_nx = OFF;
    endcase
    disc_nx = |(en_nx & DISCRETE_MASK);
  end

  always_comb begin
    mode_enable         = en_q;
    discrete_adc_enable = disc_q;
    active_mode         = act_q;
    sel_error           = err_q;
    busy                = (state == DEAD);
  end

endmodule
